seg7_count_display: RTL and testbench
=====================================

// Module: seg7_count_display
// PURPOSE
//  Downstream display stage for the 0-99 up/down counter on the Spartan-6 edge board.
//  Converts the 7-bit binary count to two BCD digits with a sequential converter.
//  Time-multiplexes the digits onto a 2-digit common-anode 7-segment display.
//  Stretches the counter's rollover flag into a visible LED pulse.
// PARAMETERS
//  REFRESH_DIV  50000     clk cycles per digit slot (50 MHz -> 1 kHz slot rate)
//  ROLL_HOLD    25000000  clk cycles roll_led stays lit after a roll rising edge
//  BLANK_LZ     1         1: tens digit blanked when tens==0; 0: show leading zero
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst        in   1  asynchronous, active-high reset
//  count      in   7  binary count from upstream counter (legal 0-99, 100-127 possible)
//  roll       in   1  rollover flag from counter; level, may stay high (sticky)
//  seg        out  7  segments {g,f,e,d,c,b,a}, active low
//  dp         out  1  decimal point, active low; always 1 (off)
//  an         out  2  digit anodes, active low; an[0]=ones, an[1]=tens
//  roll_led   out  1  stretched rollover indicator, active high
//  bcd_tens   out  4  converted tens digit
//  bcd_ones   out  4  converted ones digit
//  bcd_valid  out  1  high when bcd_* reflect the most recently captured count
// BEHAVIOUR
//  Reset (async assert, sync release): seg=7'h7F, dp=1, an=2'b11, roll_led=0,
//   bcd_tens=0, bcd_ones=0, bcd_valid=0, refresh cnt=0, digit sel=ones,
//   last_cnt forced to 7'h7F (first post-reset cycle always triggers a conversion).
//  Converter FSM (IDLE, CONV, DONE):
//   IDLE: if count!=last_cnt, capture count into work reg and last_cnt, tens_acc=0,
//    bcd_valid<=0, go CONV. Else stay, bcd_valid=1 (once first conversion done).
//   CONV: capture>99 -> go DONE with ovf=1. Else if work>=10: work-=10,
//    tens_acc+=1, stay; else go DONE with ones=work.
//   DONE: load bcd_tens/bcd_ones (ovf: both 4'hF), set bcd_valid=1, go IDLE.
//   Latency capture->bcd_valid: (count/10)+2 cycles, max 11; overflow: 2 cycles.
//   count changes during CONV/DONE are ignored until IDLE re-samples (no restart).
//  Display: displayed digits update only on DONE; scan never shows partial results.
//   Refresh counter 0..REFRESH_DIV-1; on wrap, digit sel toggles.
//   sel=ones: an=2'b10, seg=enc(ones); sel=tens: an=2'b01, seg=enc(tens) or 7'h7F
//   if BLANK_LZ && tens==0. ovf: both digits show dash 7'b0111111.
//   Encoder: 0-9 standard gfedcba active low (0=7'b1000000, 1=7'b1111001, ...,
//   9=7'b0010000); codes A-F other than ovf -> 7'h7F. seg/an registered together.
//  Roll stretcher: roll registered once, rising edge (roll & ~roll_q) loads
//   hold=ROLL_HOLD-1 and sets roll_led; hold decrements each cycle, roll_led clears
//   when hold reaches 0. New rising edge while lit re-triggers full hold. A roll
//   already high at reset release counts as an edge (roll_q resets to 0).
//  Width rules: hold counter $clog2(ROLL_HOLD), refresh $clog2(REFRESH_DIV); no wrap
//   beyond terminal values.
//  Reset mid-conversion: FSM to IDLE, bcd_valid=0, display blank until next DONE.
// STRUCTURE
//  Package seg7_pkg: SEG_DIGIT[0:9] patterns, SEG_BLANK=7'h7F, SEG_DASH=7'b0111111,
//   AN_ONES=2'b10, AN_TENS=2'b01, AN_OFF=2'b11, converter state encodings.
//  Sub-module bin2bcd_seq: converter FSM (clk, rst, count -> tens, ones, ovf, valid).
//  Top holds scan/refresh logic, encoder, and roll stretcher.
// TESTING (sim params REFRESH_DIV=4, ROLL_HOLD=8)
//  Reset then count=7'd0 -> bcd 0/0, bcd_valid by cycle 3; tens slot an=01 seg=7F.
//  count 0->99 -> bcd_valid low 11 cycles, then tens=9 ones=9; seg 7'b0010000 both.
//  count=7'd105 -> bcd F/F after 2 cycles; both slots show 7'b0111111.
//  Scan: an alternates 10/01 every 4 cycles; never 00, seg matches active digit.
//  roll 0->1 held high -> roll_led high 8 cycles then low; 2nd edge at cycle 5
//   extends to cycle 13.
//  Assert rst during CONV (count 0->87) -> outputs reset values immediately; after
//   release reconverts to 8/7.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 2-digit 7-segment count display: segment patterns,
// anode codes, converter state encodings and the digit encoder.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // gfedcba, active low, indexed by digit value
  localparam logic [0:9][6:0] SEG_DIGIT = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [1:0] AN_OFF  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Converter result; ovf marks a captured count above 99
  typedef struct packed {
    logic       ovf;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Digit codes above 9 have no glyph and show as blank
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    if (d <= 4'd9) return SEG_DIGIT[d];
    else           return SEG_BLANK;
  endfunction

endpackage

// File: rtl/seg7_count_display_if.sv
// Counter-side inputs and display-side outputs of the count display stage.
interface seg7_count_display_if;
  logic [6:0] count;
  logic       roll;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  logic       roll_led;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       bcd_valid;

  modport master (output count, roll,
                  input  seg, dp, an, roll_led, bcd_tens, bcd_ones, bcd_valid);
  modport slave  (input  count, roll,
                  output seg, dp, an, roll_led, bcd_tens, bcd_ones, bcd_valid);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: repeated subtraction of 10, one step per
// cycle. Results change only in DONE so the display never sees partial values.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] count_i,
  output bcd_t       res_o,
  output logic       valid_o
);

  logic [1:0] state_q;
  logic [6:0] last_q;
  logic [6:0] work_q;
  logic [3:0] acc_q;
  logic       ovf_q;
  bcd_t       res_q;
  logic       valid_q;

  // Converter FSM; last_q resets to 7F so the first post-reset cycle converts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 7'h7F;
      work_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (count_i != last_q) begin
            last_q  <= count_i;
            work_q  <= count_i;
            acc_q   <= '0;
            valid_q <= 1'b0;
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          // work only shrinks, so >99 can only be true on the first step
          if (work_q > 7'd99) begin
            ovf_q   <= 1'b1;
            state_q <= ST_DONE;
          end else if (work_q >= 7'd10) begin
            work_q <= work_q - 7'd10;
            acc_q  <= acc_q + 4'd1;
          end else begin
            ovf_q   <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          res_q.ovf  <= ovf_q;
          res_q.tens <= ovf_q ? 4'hF : acc_q;
          res_q.ones <= ovf_q ? 4'hF : work_q[3:0];
          valid_q    <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign res_o   = res_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/seg7_count_display.sv
// Display stage for the 0-99 counter: BCD conversion, 2-digit multiplexed
// common-anode scan, and a stretched rollover LED.
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int ROLL_HOLD   = 25000000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_count_display_if.slave  bus
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (ROLL_HOLD > 1) ? $clog2(ROLL_HOLD) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_TOP = HW'(ROLL_HOLD - 1);

  bcd_t res;
  logic valid;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst     (rst),
    .count_i (bus.count),
    .res_o   (res),
    .valid_o (valid)
  );

  logic [RW-1:0] ref_q;
  logic          sel_q;     // 0 = ones slot, 1 = tens slot
  logic          shown_q;   // a conversion has finished since reset
  logic          show;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          roll_q, led_q;
  logic [HW-1:0] hold_q;

  // Converter outputs only move in DONE, so holding onto them after the first
  // valid keeps old digits on screen while a new conversion runs
  assign show = shown_q | valid;

  // Pick the glyph for the active slot
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = sel_q ? AN_TENS : AN_ONES;
    if (show) begin
      if (res.ovf)                                    seg_d = SEG_DASH;
      else if (!sel_q)                                seg_d = seg_enc(res.ones);
      else if (BLANK_LZ != 0 && res.tens == 4'd0)     seg_d = SEG_BLANK;
      else                                            seg_d = seg_enc(res.tens);
    end
  end

  // Refresh divider, slot toggle, and registered seg/an pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q   <= '0;
      sel_q   <= 1'b0;
      shown_q <= 1'b0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
    end else begin
      if (ref_q == REF_LAST) begin
        ref_q <= '0;
        sel_q <= ~sel_q;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
      shown_q <= show;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  // Rollover stretcher: each rising edge of roll (re)loads the full hold time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      roll_q <= 1'b0;
      led_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      roll_q <= bus.roll;
      if (bus.roll && !roll_q) begin
        hold_q <= HOLD_TOP;
        led_q  <= 1'b1;
      end else if (led_q) begin
        if (hold_q == '0) led_q  <= 1'b0;
        else              hold_q <= hold_q - 1'b1;
      end
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dp        = 1'b1;
  assign bus.an        = an_q;
  assign bus.roll_led  = led_q;
  assign bus.bcd_tens  = res.tens;
  assign bus.bcd_ones  = res.ones;
  assign bus.bcd_valid = valid;

endmodule

// File: tb/tb_seg7_count_display.sv
// Directed bench for seg7_count_display with REFRESH_DIV=4, ROLL_HOLD=8.
module tb_seg7_count_display;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seg7_count_display_if bus ();

  seg7_count_display #(
    .REFRESH_DIV (4),
    .ROLL_HOLD   (8),
    .BLANK_LZ    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] cnt;
    int         tens;
    int         ones;
    int         lat;   // ticks from driving count to first bcd_valid sample
  } vec_t;

  vec_t vt [7];

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.bcd_valid && n < 40);
    if (!bus.bcd_valid) begin
      errors++;
      $display("FAIL wait_valid: bcd_valid not seen within %0d cycles", n);
    end
  endtask

  // Watch 12 cycles of scan: legal anode, matching glyph, 4-cycle slot length
  task automatic scan(input logic [6:0] s_ones, input logic [6:0] s_tens);
    logic [1:0] prev;
    int run;
    bit seen;
    prev = bus.an;
    run  = 1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("scan_an_legal", int'(bus.an == 2'b10 || bus.an == 2'b01), 1);
      if (bus.an == 2'b10) chk("scan_seg_ones", bus.seg, s_ones);
      else                 chk("scan_seg_tens", bus.seg, s_tens);
      if (bus.an != prev) begin
        if (seen) chk("scan_slot_len", run, 4);
        seen = 1;
        run  = 1;
        prev = bus.an;
      end else begin
        run++;
      end
    end
  endtask

  task automatic expect_digits(input int tens, input int ones);
    logic [6:0] so, st;
    bit ovf;
    chk("bcd_tens", bus.bcd_tens, tens);
    chk("bcd_ones", bus.bcd_ones, ones);
    ovf = (tens == 15);
    so = ovf ? 7'b0111111 : enc(ones);
    st = ovf ? 7'b0111111 : (tens == 0 ? 7'h7F : enc(tens));
    tick();
    tick();
    scan(so, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0] = '{7'd99,  9,  9, 12};
    vt[1] = '{7'd105, 15, 15, 3};
    vt[2] = '{7'd42,  4,  2, 7};
    vt[3] = '{7'd7,   0,  7, 3};
    vt[4] = '{7'd100, 15, 15, 3};
    vt[5] = '{7'd10,  1,  0, 4};
    vt[6] = '{7'd127, 15, 15, 3};

    rst = 1'b1;
    bus.count = 7'd0;
    bus.roll  = 1'b0;
    tick();
    tick();
    chk("rst_seg",      bus.seg, 7'h7F);
    chk("rst_dp",       bus.dp, 1);
    chk("rst_an",       bus.an, 2'b11);
    chk("rst_roll_led", bus.roll_led, 0);
    chk("rst_tens",     bus.bcd_tens, 0);
    chk("rst_ones",     bus.bcd_ones, 0);
    chk("rst_valid",    bus.bcd_valid, 0);
    rst = 1'b0;

    // first conversion after reset: count 0, valid on the third edge
    tick();
    tick();
    chk("init_valid_c2", bus.bcd_valid, 0);
    tick();
    chk("init_valid_c3", bus.bcd_valid, 1);
    expect_digits(0, 0);
    chk("dp_off", bus.dp, 1);

    for (int i = 0; i < 7; i++) begin
      bus.count = vt[i].cnt;
      wait_valid(n);
      chk("latency", n, vt[i].lat);
      expect_digits(vt[i].tens, vt[i].ones);
    end

    // count change mid-conversion is ignored until IDLE, then reconverted
    bus.count = 7'd99;
    tick();
    tick();
    tick();
    bus.count = 7'd5;
    wait_valid(n);
    chk("midchg_latency", n, 9);
    chk("midchg_tens", bus.bcd_tens, 9);
    chk("midchg_ones", bus.bcd_ones, 9);
    tick();
    chk("midchg_valid_drop", bus.bcd_valid, 0);
    wait_valid(n);
    chk("midchg_relat", n, 2);
    expect_digits(0, 5);

    // roll held high: one 8-cycle pulse, no re-trigger while sticky
    bus.roll = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("roll_single", bus.roll_led, int'(k <= 8));
    end

    // second rising edge at cycle 5 extends the pulse to cycle 13
    bus.roll = 1'b0;
    tick();
    for (int k = 1; k <= 14; k++) begin
      bus.roll = (k == 4) ? 1'b0 : 1'b1;
      tick();
      chk("roll_retrig", bus.roll_led, int'(k <= 12));
    end
    bus.roll = 1'b0;

    // reset in the middle of converting 87
    bus.count = 7'd87;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_seg",   bus.seg, 7'h7F);
    chk("midrst_an",    bus.an, 2'b11);
    chk("midrst_valid", bus.bcd_valid, 0);
    chk("midrst_tens",  bus.bcd_tens, 0);
    chk("midrst_ones",  bus.bcd_ones, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_blank", bus.seg, 7'h7F);
    wait_valid(n);
    chk("midrst_latency", n, 10);
    expect_digits(8, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
